// File: rtl/demux_pkg.sv
// ---------------------------------------------------------------------------
// demux_pkg
//   Shared types and helpers for the stream_demux block.
//   - demux_state_t : packet-lock FSM states (only used when DEMUX_LOCK_EN is
//                     defined).
//   - sel_width(n)  : width of the channel-select field for n output channels.
//                     Two channels still get a 1-bit select, so the result is
//                     never zero.
// ---------------------------------------------------------------------------
package demux_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } demux_state_t;

    function automatic int sel_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/demux_out_slot.sv
// ---------------------------------------------------------------------------
// demux_out_slot
//   One-entry valid/ready output register for a single demux channel.
//   Ports:
//     clock, reset   rising-edge clock, synchronous active-high reset
//     load           write load_data into the register this cycle
//     load_data      WIDTH-bit payload to store
//     out_ready      downstream consumer ready
//     out_valid      register holds a beat
//     out_data       stored payload (holds last value while out_valid=0)
//     can_load       register can take a beat this cycle (empty or draining)
// ---------------------------------------------------------------------------
module demux_out_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             can_load
);

    logic             valid_reg;
    logic [WIDTH-1:0] data_reg;

    // Draining and loading in the same cycle is allowed, giving one beat per
    // cycle per channel.
    assign can_load  = !valid_reg || out_ready;
    assign out_valid = valid_reg;
    assign out_data  = data_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (load) begin
            valid_reg <= 1'b1;
            data_reg  <= load_data;
        end else if (valid_reg && out_ready) begin
            valid_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// ---------------------------------------------------------------------------
// stream_demux
//   1-to-NUM_OUT registered stream demultiplexer with valid/ready handshake.
//   Each accepted beat is written into the output register of the channel
//   selected by in_sel; a select beyond NUM_OUT-1 is accepted and discarded,
//   raising drop_pulse for one cycle and bumping a saturating drop_count.
//
//   Optional feature macro: DEMUX_LOCK_EN
//     When defined, the select of the first beat of a packet is latched and
//     all beats up to and including the one with in_last=1 follow it.
//     When undefined, every beat is routed by its own in_sel and in_last is
//     ignored.
//
//   Ports:
//     clock, reset   rising-edge clock, synchronous active-high reset
//     in_valid/in_ready/in_data/in_sel/in_last   input stream
//     out_valid/out_ready  per-channel handshake (NUM_OUT bits)
//     out_data       channel i at [i*WIDTH +: WIDTH]
//     drop_pulse     one-cycle flag: a beat was discarded
//     drop_count     saturating count of discarded beats
// ---------------------------------------------------------------------------
module stream_demux
    import demux_pkg::*;
#(
    parameter  int WIDTH   = 8,
    parameter  int NUM_OUT = 4,
    parameter  int CNTW    = 8,
    localparam int SELW    = sel_width(NUM_OUT)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [SELW-1:0]          in_sel,
    input  logic                     in_last,
    output logic [NUM_OUT-1:0]       out_valid,
    input  logic [NUM_OUT-1:0]       out_ready,
    output logic [NUM_OUT*WIDTH-1:0] out_data,
    output logic                     drop_pulse,
    output logic [CNTW-1:0]          drop_count
);

    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic [SELW-1:0]    target;
    logic               target_ok;
    logic               accept;
    logic [NUM_OUT-1:0] slot_can_load;
    logic [NUM_OUT-1:0] slot_load;
    logic               drop_pulse_reg;
    logic [CNTW-1:0]    drop_count_reg;

`ifdef DEMUX_LOCK_EN
    demux_state_t    state_reg;
    logic [SELW-1:0] lock_sel_reg;

    // Inside a packet the latched select wins over whatever in_sel shows.
    assign target = (state_reg == ST_LOCKED) ? lock_sel_reg : in_sel;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            lock_sel_reg <= '0;
        end else if (accept) begin
            case (state_reg)
                ST_IDLE: begin
                    // Single-beat packets never enter the locked state.
                    if (!in_last) begin
                        state_reg    <= ST_LOCKED;
                        lock_sel_reg <= in_sel;
                    end
                end
                ST_LOCKED: begin
                    if (in_last) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end
`else
    logic unused_last;

    assign target      = in_sel;
    assign unused_last = in_last;
`endif

    assign target_ok = (int'(target) < NUM_OUT);

    // Ready depends only on the target channel's register, never on in_valid.
    // Beats to a nonexistent channel are always taken so they can be dropped.
    always_comb begin
        in_ready = 1'b1;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (target == SELW'(i)) begin
                in_ready = slot_can_load[i];
            end
        end
    end

    assign accept = in_valid && in_ready;

    generate
        for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_slot
            assign slot_load[gi] = accept && (target == SELW'(gi));

            demux_out_slot #(
                .WIDTH(WIDTH)
            ) u_slot (
                .clock    (clock),
                .reset    (reset),
                .load     (slot_load[gi]),
                .load_data(in_data),
                .out_ready(out_ready[gi]),
                .out_valid(out_valid[gi]),
                .out_data (out_data[gi*WIDTH +: WIDTH]),
                .can_load (slot_can_load[gi])
            );
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            drop_pulse_reg <= 1'b0;
            drop_count_reg <= '0;
        end else begin
            drop_pulse_reg <= accept && !target_ok;
            if (accept && !target_ok && (drop_count_reg != CNT_MAX)) begin
                drop_count_reg <= drop_count_reg + CNTW'(1);
            end
        end
    end

    assign drop_pulse = drop_pulse_reg;
    assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_stream_demux.sv
// ---------------------------------------------------------------------------
// tb_stream_demux
//   Two instances share one input stream: u4 (NUM_OUT=4, every select is a
//   real channel) and u3 (NUM_OUT=3, select 3 is discarded). A queue-free
//   behavioural model tracks, per instance, which channels hold a beat, the
//   drop counter and the open packet (lock builds).
// ---------------------------------------------------------------------------
module tb_stream_demux;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_last;
    logic [3:0]  o_ready;

    logic        rdy4, rdy3;
    logic [3:0]  v4;
    logic [2:0]  v3;
    logic [31:0] d4;
    logic [23:0] d3;
    logic        p4, p3;
    logic [7:0]  c4, c3;

    int vectors;
    int miscompares;

    stream_demux #(.WIDTH(8), .NUM_OUT(4), .CNTW(8)) u4 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy4),
        .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
        .out_valid(v4), .out_ready(o_ready), .out_data(d4),
        .drop_pulse(p4), .drop_count(c4)
    );

    stream_demux #(.WIDTH(8), .NUM_OUT(3), .CNTW(8)) u3 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy3),
        .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
        .out_valid(v3), .out_ready(o_ready[2:0]), .out_data(d3),
        .drop_pulse(p3), .drop_count(c3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    bit         m_v   [2][4];
    logic [7:0] m_d   [2][4];
    int         m_cnt [2];
    bit         m_p   [2];
    bit         m_pkt [2];
    int         m_dst [2];
    bit         exp_rdy [2];
    bit         act_rdy [2];

    function automatic int nout(input int d);
        return (d == 0) ? 4 : 3;
    endfunction

    function automatic int m_dest(input int d);
`ifdef DEMUX_LOCK_EN
        if (m_pkt[d]) return m_dst[d];
`endif
        return int'(in_sel);
    endfunction

    function automatic bit m_ready(input int d);
        int dest;
        dest = m_dest(d);
        if (dest >= nout(d)) return 1'b1;
        return !m_v[d][dest] || o_ready[dest];
    endfunction

    function automatic logic [3:0] e_valid(input int d);
        logic [3:0] r;
        r = '0;
        for (int c = 0; c < nout(d); c++) r[c] = m_v[d][c];
        return r;
    endfunction

    function automatic logic [31:0] e_data(input int d);
        logic [31:0] r;
        r = '0;
        for (int c = 0; c < nout(d); c++) r[c*8 +: 8] = m_d[d][c];
        return r;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 4; c++) begin
                m_v[d][c] = 1'b0;
                m_d[d][c] = 8'h00;
            end
            m_cnt[d] = 0;
            m_p[d]   = 1'b0;
            m_pkt[d] = 1'b0;
            m_dst[d] = 0;
        end
    endtask

    task automatic drive(input bit v, input int s, input logic [7:0] dat,
                         input bit last, input logic [3:0] rdy);
        in_valid = v;
        in_sel   = s[1:0];
        in_data  = dat;
        in_last  = last;
        o_ready  = rdy;
    endtask

    // Advance one clock: capture pre-edge ready, then update the model with
    // the inputs that were presented across the edge.
    task automatic tick();
        int  dest;
        bit  ok, acc;
        #3;
        act_rdy[0] = rdy4;
        act_rdy[1] = rdy3;
        for (int d = 0; d < 2; d++) exp_rdy[d] = m_ready(d);
        @(posedge clock);
        if (reset) begin
            model_clear();
        end else begin
            for (int d = 0; d < 2; d++) begin
                dest = m_dest(d);
                ok   = dest < nout(d);
                acc  = in_valid && exp_rdy[d];
                for (int c = 0; c < nout(d); c++)
                    if (m_v[d][c] && o_ready[c]) m_v[d][c] = 1'b0;
                if (acc && ok) begin
                    m_v[d][dest] = 1'b1;
                    m_d[d][dest] = in_data;
                end
                m_p[d] = acc && !ok;
                if (m_p[d] && m_cnt[d] < 255) m_cnt[d]++;
`ifdef DEMUX_LOCK_EN
                if (acc) begin
                    if (!m_pkt[d] && !in_last) begin
                        m_pkt[d] = 1'b1;
                        m_dst[d] = int'(in_sel);
                    end else if (m_pkt[d] && in_last) begin
                        m_pkt[d] = 1'b0;
                    end
                end
`endif
            end
        end
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1, $urandom_range(0, 3), 8'($urandom), $urandom_range(0, 1), 4'($urandom));
            tick();
        end
        reset = 1'b0;
        drive(0, 0, 8'h00, 1, 4'h0);
        vectors++;
        if (v4 !== 4'h0 || v3 !== 3'h0) begin
            miscompares++;
            $display("FAIL reset_valid: got %h/%h expected 0/0", v4, v3);
        end
        vectors++;
        if (c4 !== 8'h00 || c3 !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_count: got %h/%h expected 0/0", c4, c3);
        end
        vectors++;
        if (p4 !== 1'b0 || p3 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_pulse: got %b/%b expected 0/0", p4, p3);
        end
        vectors++;
        if (d4 !== 32'h0 || d3 !== 24'h0) begin
            miscompares++;
            $display("FAIL reset_data: got %h/%h expected 0/0", d4, d3);
        end
        $display("reset: valid=%h/%h count=%0d/%0d", v4, v3, c4, c3);
    endtask

    task automatic test_routing();
        logic [7:0] want;
        for (int s = 0; s < 4; s++) begin
            want = 8'hA0 + 8'(s);
            drive(1, s, want, 1, 4'hF);
            tick();
            vectors++;
            if (act_rdy[0] !== 1'b1) begin
                miscompares++;
                $display("FAIL route_ready s=%0d: got %b expected 1", s, act_rdy[0]);
            end
            vectors++;
            if (v4 !== (4'b0001 << s)) begin
                miscompares++;
                $display("FAIL route_valid s=%0d: got %b expected %b", s, v4, 4'b0001 << s);
            end
            vectors++;
            if (d4[s*8 +: 8] !== want) begin
                miscompares++;
                $display("FAIL route_data s=%0d: got %h expected %h", s, d4[s*8 +: 8], want);
            end
            vectors++;
            if (v3 !== e_valid(1) || p3 !== m_p[1]) begin
                miscompares++;
                $display("FAIL route_u3 s=%0d: got v=%b p=%b expected v=%b p=%b",
                         s, v3, p3, e_valid(1), m_p[1]);
            end
            $display("route: sel=%0d data=%h out_valid=%b", s, want, v4);
        end
    endtask

    task automatic test_backpressure();
        // step: sel, data, ready mask, expected in_ready(u4), expected ch2 data after
        int         sel_t [6] = '{2, 2, 2, 1, 2, 0};
        logic [7:0] dat_t [6] = '{8'hC0, 8'hC1, 8'hC1, 8'hB1, 8'hC1, 8'h00};
        logic [3:0] rdy_t [6] = '{4'hB, 4'hB, 4'hB, 4'hB, 4'hF, 4'hF};
        bit         vin_t [6] = '{1, 1, 1, 1, 1, 0};
        bit         ir_t  [6] = '{1, 0, 0, 1, 1, 1};
        logic [7:0] c2_t  [6] = '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC1, 8'hC1};
        bit         v2_t  [6] = '{1, 1, 1, 1, 1, 0};
        for (int k = 0; k < 6; k++) begin
            drive(vin_t[k], sel_t[k], dat_t[k], 1, rdy_t[k]);
            tick();
            vectors++;
            if (act_rdy[0] !== ir_t[k] || act_rdy[1] !== ir_t[k]) begin
                miscompares++;
                $display("FAIL bp_ready step%0d: got %b/%b expected %b", k, act_rdy[0], act_rdy[1], ir_t[k]);
            end
            vectors++;
            if (v4[2] !== v2_t[k] || d4[23:16] !== c2_t[k] || v3[2] !== v2_t[k] || d3[23:16] !== c2_t[k]) begin
                miscompares++;
                $display("FAIL bp_ch2 step%0d: got %b:%h/%b:%h expected %b:%h",
                         k, v4[2], d4[23:16], v3[2], d3[23:16], v2_t[k], c2_t[k]);
            end
            vectors++;
            if (v4 !== e_valid(0) || d4 !== e_data(0)) begin
                miscompares++;
                $display("FAIL bp_model step%0d: got %b:%h expected %b:%h", k, v4, d4, e_valid(0), e_data(0));
            end
            $display("backpressure: step=%0d sel=%0d in_ready=%b ch2=%b:%h", k, sel_t[k], act_rdy[0], v4[2], d4[23:16]);
        end
    endtask

    task automatic test_random(input int n);
        logic [3:0]  ev, av;
        logic [31:0] ed, ad;
        bit          ap;
        logic [7:0]  ac;
        for (int i = 0; i < n; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3), 8'($urandom),
                  $urandom_range(0, 2) == 0, 4'($urandom));
            tick();
            for (int d = 0; d < 2; d++) begin
                ev = e_valid(d);
                ed = e_data(d);
                av = (d == 0) ? v4 : {1'b0, v3};
                ad = (d == 0) ? d4 : {8'h00, d3};
                ap = (d == 0) ? p4 : p3;
                ac = (d == 0) ? c4 : c3;
                vectors++;
                if (act_rdy[d] !== exp_rdy[d]) begin
                    miscompares++;
                    $display("FAIL rand_ready d%0d cyc%0d: got %b expected %b", d, i, act_rdy[d], exp_rdy[d]);
                end
                vectors++;
                if (av !== ev || ad !== ed) begin
                    miscompares++;
                    $display("FAIL rand_out d%0d cyc%0d: got %b:%h expected %b:%h", d, i, av, ad, ev, ed);
                end
                vectors++;
                if (ap !== m_p[d] || ac !== 8'(m_cnt[d])) begin
                    miscompares++;
                    $display("FAIL rand_drop d%0d cyc%0d: got %b/%0d expected %b/%0d", d, i, ap, ac, m_p[d], m_cnt[d]);
                end
            end
            $display("random: cyc=%0d v=%b sel=%0d data=%h rdy=%b/%b", i, in_valid, in_sel, in_data, act_rdy[0], act_rdy[1]);
        end
    endtask

    task automatic test_reset_mid();
        // Traffic keeps flowing while reset is held.
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1, $urandom_range(0, 3), 8'($urandom), 0, 4'h0);
            tick();
        end
        reset = 1'b0;
        drive(0, 0, 8'h00, 1, 4'hF);
        vectors++;
        if (v4 !== 4'h0 || v3 !== 3'h0 || c4 !== 8'h00 || c3 !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_mid: got v=%h/%h c=%0d/%0d expected 0", v4, v3, c4, c3);
        end
        $display("reset_mid: valid=%h/%h count=%0d/%0d", v4, v3, c4, c3);
    endtask

    task automatic test_drop();
        int want;
        for (int i = 0; i < 300; i++) begin
            drive(1, 3, 8'($urandom), 1, 4'hF);
            tick();
            want = (i + 1 > 255) ? 255 : i + 1;
            vectors++;
            if (act_rdy[1] !== 1'b1 || p3 !== 1'b1 || c3 !== 8'(want)) begin
                miscompares++;
                $display("FAIL drop beat%0d: got rdy=%b p=%b c=%0d expected 1/1/%0d", i, act_rdy[1], p3, c3, want);
            end
            vectors++;
            if (p4 !== 1'b0 || c4 !== 8'h00 || v4 !== e_valid(0)) begin
                miscompares++;
                $display("FAIL drop_u4 beat%0d: got p=%b c=%0d v=%b expected 0/0/%b", i, p4, c4, v4, e_valid(0));
            end
            if (i % 50 == 0 || i > 252 && i < 258)
                $display("drop: beat=%0d pulse=%b count=%0d", i, p3, c3);
        end
        drive(0, 3, 8'h00, 1, 4'hF);
        tick();
        vectors++;
        if (p3 !== 1'b0 || c3 !== 8'd255) begin
            miscompares++;
            $display("FAIL drop_idle: got p=%b c=%0d expected 0/255", p3, c3);
        end
        $display("drop: idle pulse=%b count=%0d", p3, c3);
    endtask

`ifdef DEMUX_LOCK_EN
    task automatic test_lock();
        int         sel_t  [4] = '{1, 0, 2, 0};
        bit         last_t [4] = '{0, 0, 1, 1};
        logic [7:0] dat_t  [4] = '{8'h51, 8'h52, 8'h53, 8'h60};
        int         ch_t   [4] = '{1, 1, 1, 0};
        for (int k = 0; k < 4; k++) begin
            drive(1, sel_t[k], dat_t[k], last_t[k], 4'hF);
            tick();
            vectors++;
            if (v4 !== (4'b0001 << ch_t[k]) || d4[ch_t[k]*8 +: 8] !== dat_t[k]) begin
                miscompares++;
                $display("FAIL lock_u4 beat%0d: got v=%b d=%h expected ch%0d %h",
                         k, v4, d4[ch_t[k]*8 +: 8], ch_t[k], dat_t[k]);
            end
            vectors++;
            if (v3 !== (3'b001 << ch_t[k]) || d3[ch_t[k]*8 +: 8] !== dat_t[k]) begin
                miscompares++;
                $display("FAIL lock_u3 beat%0d: got v=%b d=%h expected ch%0d %h",
                         k, v3, d3[ch_t[k]*8 +: 8], ch_t[k], dat_t[k]);
            end
            $display("lock: beat=%0d in_sel=%0d last=%b out_valid=%b", k, sel_t[k], last_t[k], v4);
        end
    endtask

    task automatic test_lock_reset();
        drive(1, 2, 8'h71, 0, 4'hF);
        tick();
        reset = 1'b1;
        drive(0, 2, 8'h00, 0, 4'hF);
        tick();
        reset = 1'b0;
        drive(1, 0, 8'h72, 1, 4'hF);
        tick();
        vectors++;
        if (v4 !== 4'b0001 || d4[7:0] !== 8'h72 || v3 !== 3'b001 || d3[7:0] !== 8'h72) begin
            miscompares++;
            $display("FAIL lock_reset: got v=%b/%b d=%h/%h expected 0001/001 72",
                     v4, v3, d4[7:0], d3[7:0]);
        end
        $display("lock_reset: out_valid=%b data=%h", v4, d4[7:0]);
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_clear();
        drive(0, 0, 8'h00, 1, 4'h0);
        test_reset();
        test_routing();
        test_backpressure();
        test_random(300);
        test_reset_mid();
        test_drop();
        test_random(100);
`ifdef DEMUX_LOCK_EN
        test_reset();
        test_lock();
        test_lock_reset();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
